serial_parity_rx: RTL
=====================

Name: serial_parity_rx

Overview:
Serial frame receiver and parity checker, directly downstream of the serial parity generator stage.
- Consumes a one-bit-per-clock serial line carrying start bit, DATA_W data bits (LSB first), one parity bit and a stop bit.
- Reassembles the data word and checks parity and framing.
- Presents the word with a one-cycle valid strobe to the parallel logic that follows.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 2..16)
ODD, 0, parity sense: 0 = even (data bits XOR parity bit must equal 0), 1 = odd (must equal 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
x  input  1  serial line, sampled once per rising clk edge; idles high
data  output  DATA_W  last received data word, bit 0 = first data bit received
valid  output  1  one-cycle strobe: data/parity_err/frame_err updated this cycle
parity_err  output  1  parity check failed for the frame flagged by valid
frame_err  output  1  stop bit sampled as 0 for the frame flagged by valid
busy  output  1  high while in any state other than IDLE
err_cnt  output  8  count of frames with parity_err or frame_err, saturates at 255

Behaviour:
- Reset: when rst is high at a rising edge, the following all go to 0:
  - state=IDLE
  - data, valid, parity_err, frame_err, busy, err_cnt
  - bit counter and running parity
- rst has priority over all other activity, including a frame in progress. The partial frame is discarded with no valid pulse.
- FSM states and transitions:
  - IDLE: x==0 at an edge -> DATA, bit counter=0, running parity=0; x==1 -> stay in IDLE.
  - DATA: each edge shifts x into the shift register at position bit_cnt (LSB first), XORs x into running parity and increments bit_cnt. After the edge that samples bit DATA_W-1 -> PARITY.
  - PARITY: the edge samples the parity bit and XORs it into running parity -> STOP.
  - STOP: the edge samples the stop bit.
    - Registers data=shift register.
    - parity_err = (running parity != ODD).
    - frame_err = (x==0).
    - valid=1.
    - Next state -> IDLE.
- Timing, for a start bit sampled at edge k:
  - Data bits are sampled at edges k+1..k+DATA_W.
  - The parity bit is sampled at edge k+DATA_W+1.
  - The stop bit is sampled at edge k+DATA_W+2.
  - valid is high for exactly the cycle after edge k+DATA_W+2 and is cleared at the next edge.
- Output holding:
  - data, parity_err and frame_err hold their values until the next STOP edge.
  - They are not cleared when valid drops.
- Framing-error recovery:
  - On a framing error, the 0 sampled as the stop bit is NOT treated as a start bit.
  - The FSM returns to IDLE and waits for the next 0 sampled in IDLE.
- Back-to-back frames: a start bit sampled at edge k+DATA_W+3, i.e. the first edge in IDLE, is accepted. Minimum frame period is DATA_W+3 cycles with no gap required.
- A frame may carry both parity_err and frame_err.
- err_cnt increments by exactly 1 on a STOP edge where (parity_err | frame_err) is set. It holds at 255.
- busy is high in DATA, PARITY and STOP, and low in IDLE, including the valid cycle.
- No glitch filtering or oversampling: the line is assumed synchronous to clk, changing between edges.

Test Plan:
1. Reset, then hold x=1 for 20 cycles -> valid never asserts; busy=0, data=0, err_cnt=0.
2. DATA_W=8, ODD=0: send frame 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1) with start sampled at edge k.
   - Required: valid=1 only in the cycle after edge k+10; data=8'hA5; parity_err=0; frame_err=0; err_cnt=0.
3. Send 0x07 with parity bit 0 and stop bit 1.
   - Required: valid pulse; data=8'h07; parity_err=1; frame_err=0; err_cnt=1.
   - Then send 0x07 with parity 1 -> parity_err=0; err_cnt stays 1.
4. Send 0x3C (parity 0) with stop bit 0, then x=1 for 2 cycles, then a valid 0x81 frame (parity 0).
   - 0x3C frame: data=8'h3C, frame_err=1, parity_err=0, err_cnt increments.
   - 0x81 frame: exactly one additional valid with data=8'h81, no errors.
5. Two frames back-to-back with no idle gap: 0x55 then 0xF0, both parity 0, stop 1.
   - Required: two valid pulses exactly 11 cycles apart carrying 8'h55 then 8'hF0; busy drops to 0 for one cycle between them.
6. Mid-frame reset and counter saturation:
   - Assert rst for one cycle after the 4th data bit of 0xA5, then send a clean 0x12 frame -> only one valid (data=8'h12), err_cnt=0.
   - Then send 300 parity-error frames -> err_cnt=255.

Source files
------------

// File: rtl/serial_parity_rx.sv
// Serial frame receiver.
// Frame format: start(0), DATA_W data bits (LSB first), parity bit, stop(1).
// The received word is presented with a one-cycle valid strobe, together
// with parity and framing flags. A saturating counter tracks bad frames.
module serial_parity_rx #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic [7:0]          errc_q, errc_d;
    logic                bad_frame;

    // State and output registers; reset discards any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            errc_q  <= errc_d;
        end
    end

    // Next-state logic: walk the frame one bit per edge, publish on the stop edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        sh_d      = sh_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        errc_d    = errc_q;
        bad_frame = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!x) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            S_DATA: begin
                sh_d[cnt_q] = x;
                par_d       = par_q ^ x;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_W - 1)) state_d = S_PARITY;
            end
            S_PARITY: begin
                par_d   = par_q ^ x;
                state_d = S_STOP;
            end
            S_STOP: begin
                // A 0 stop bit is only a framing error; it never doubles as a start bit.
                bad_frame = (par_q != ODD) || !x;
                data_d    = sh_q;
                perr_d    = (par_q != ODD);
                ferr_d    = !x;
                valid_d   = 1'b1;
                if (bad_frame && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);
    assign err_cnt    = errc_q;

endmodule
